// File: rtl/eth_frame_pkg.sv
// Shared types and header lane packing for the multi-channel Ethernet frame former.
// ETH_FRAME_FORMER_PAD_EN adds the zero-padding state for frames whose payload ends early.
package eth_frame_pkg;

  localparam int unsigned HDR_BYTES = 16;

  typedef struct packed {
    logic [47:0] da;
    logic [47:0] sa;
    logic [15:0] lt;
    logic [15:0] sw;
  } eth_hdr_t;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StPayload,
`ifdef ETH_FRAME_FORMER_PAD_EN
    StPad,
`endif
    StDrain
  } ff_state_e;

  // Header byte b (network order) lands on lane j of beat idx, where b = idx*data_bytes + j.
  function automatic logic [8*HDR_BYTES-1:0] hdr_beat(eth_hdr_t hdr, int unsigned idx,
                                                      int unsigned data_bytes);
    logic [8*HDR_BYTES-1:0] flat;
    logic [8*HDR_BYTES-1:0] beat;
    int unsigned            b;
    flat = hdr;
    beat = '0;
    for (int unsigned j = 0; j < HDR_BYTES; j++) begin
      b = idx * data_bytes + j;
      if (j < data_bytes && b < HDR_BYTES) begin
        beat[8*j +: 8] = flat[8*(HDR_BYTES-1-b) +: 8];
      end
    end
    return beat;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI4-Stream register slice: fully registered outputs, ready decoupled from m_ready_i.
module axis_skid_buf #(
  parameter int unsigned W = 65
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] s_data_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  output logic [W-1:0] m_data_o,
  output logic         m_valid_o,
  input  logic         m_ready_i
);

  logic [W-1:0] out_q, skid_q;
  logic         out_vld_q, skid_vld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (m_ready_i || !out_vld_q) begin
      if (skid_vld_q) begin
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= 1'b0;
      end else begin
        out_vld_q <= s_valid_i;
        if (s_valid_i) out_q <= s_data_i;
      end
    end else if (s_valid_i && !skid_vld_q) begin
      // Output stalled: park the beat that was accepted on the last registered ready.
      skid_q     <= s_data_i;
      skid_vld_q <= 1'b1;
    end
  end

  assign s_ready_o = !skid_vld_q;
  assign m_data_o  = out_q;
  assign m_valid_o = out_vld_q;

endmodule

// File: rtl/eth_frame_former_mc.sv
// Round-robin multi-channel frame former: 16-byte header + fixed-length payload per frame.
// Define ETH_FRAME_FORMER_PAD_EN to zero-pad early-terminated payloads up to Packet_Size.
module eth_frame_former_mc
  import eth_frame_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned PS_W       = 14
) (
  input  logic                                         ACLK,
  input  logic                                         ARESET,
  input  logic [47:0]                                  Destination_Address,
  input  logic [47:0]                                  Source_Address,
  input  logic [16*NUM_CH-1:0]                         Link_Type,
  input  logic [15:0]                                  SyncWord,
  input  logic [PS_W-1:0]                              Packet_Size,
  input  logic [NUM_CH*8*DATA_BYTES-1:0]               S_TDATA,
  input  logic [NUM_CH-1:0]                            S_TVALID,
  input  logic [NUM_CH-1:0]                            S_TLAST,
  output logic [NUM_CH-1:0]                            S_TREADY,
  output logic [8*DATA_BYTES-1:0]                      M_TDATA,
  output logic [DATA_BYTES-1:0]                        M_TKEEP,
  output logic                                         M_TVALID,
  output logic                                         M_TLAST,
  input  logic                                         M_TREADY,
  output logic [31:0]                                  Frame_Count,
  output logic                                         Frame_Err,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] Active_Ch
);

  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DW        = 8 * DATA_BYTES;
  localparam int unsigned HDR_BEATS = HDR_BYTES / DATA_BYTES;
  localparam int unsigned HI_W      = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

  ff_state_e          state_q;
  eth_hdr_t           hdr_q;
  logic [PS_W-1:0]    ps_q, cnt_q;
  logic [HI_W-1:0]    hidx_q;
  logic [CH_W-1:0]    ch_q, last_q;
  logic               err_q;
  logic [31:0]        fcnt_q;

  logic               gnt_valid;
  logic [CH_W-1:0]    gnt_ch, cand;
  logic [8*HDR_BYTES-1:0] hdr_word;
  logic               unused_hdr_word;
  logic               push_valid, push_last, push_fire, buf_ready;
  logic [DW-1:0]      push_data;
  logic [DW-1:0]      s_data_ch;
  logic               s_valid_ch, s_last_ch;
  logic [PS_W-1:0]    cnt_nxt;
  logic               hit;

  // Search starts one past the last granted channel.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_ch    = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((32'(last_q) + i) % NUM_CH);
      if (!gnt_valid && S_TVALID[cand]) begin
        gnt_valid = 1'b1;
        gnt_ch    = cand;
      end
    end
    if (Packet_Size == '0) gnt_valid = 1'b0;
  end

  assign s_data_ch  = S_TDATA[ch_q*DW +: DW];
  assign s_valid_ch = S_TVALID[ch_q];
  assign s_last_ch  = S_TLAST[ch_q];
  assign cnt_nxt    = cnt_q + 1'b1;
  assign hit        = (cnt_nxt == ps_q);
  assign hdr_word   = hdr_beat(hdr_q, 32'(hidx_q), DATA_BYTES);
  assign unused_hdr_word = ^hdr_word;

  always_comb begin
    push_valid = 1'b0;
    push_data  = '0;
    push_last  = 1'b0;
    S_TREADY   = '0;
    case (state_q)
      StHdr: begin
        push_valid = 1'b1;
        push_data  = hdr_word[DW-1:0];
      end
      StPayload: begin
        S_TREADY[ch_q] = buf_ready;
        push_valid     = s_valid_ch;
        push_data      = s_data_ch;
`ifdef ETH_FRAME_FORMER_PAD_EN
        push_last      = hit;
`else
        push_last      = s_last_ch || hit;
`endif
      end
`ifdef ETH_FRAME_FORMER_PAD_EN
      StPad: begin
        push_valid = 1'b1;
        push_last  = hit;
      end
`endif
      StDrain: S_TREADY[ch_q] = 1'b1;
      default: ;
    endcase
  end

  assign push_fire = push_valid && buf_ready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= StIdle;
      hdr_q   <= '0;
      ps_q    <= '0;
      cnt_q   <= '0;
      hidx_q  <= '0;
      ch_q    <= '0;
      last_q  <= CH_W'(NUM_CH - 1);
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      err_q <= 1'b0;
      if (M_TVALID && M_TREADY && M_TLAST) fcnt_q <= fcnt_q + 32'd1;
      case (state_q)
        StIdle: if (gnt_valid) begin
          hdr_q   <= '{da: Destination_Address, sa: Source_Address,
                       lt: Link_Type[16*gnt_ch +: 16], sw: SyncWord};
          ps_q    <= Packet_Size;
          ch_q    <= gnt_ch;
          last_q  <= gnt_ch;
          cnt_q   <= '0;
          hidx_q  <= '0;
          state_q <= StHdr;
        end
        StHdr: if (push_fire) begin
          hidx_q <= hidx_q + 1'b1;
          if (hidx_q == HI_W'(HDR_BEATS - 1)) state_q <= StPayload;
        end
        StPayload: if (push_fire) begin
          cnt_q <= cnt_nxt;
          if (hit) begin
            err_q   <= !s_last_ch;
            state_q <= s_last_ch ? StIdle : StDrain;
          end else if (s_last_ch) begin
            err_q   <= 1'b1;
`ifdef ETH_FRAME_FORMER_PAD_EN
            state_q <= StPad;
`else
            state_q <= StIdle;
`endif
          end
        end
`ifdef ETH_FRAME_FORMER_PAD_EN
        StPad: if (push_fire) begin
          cnt_q <= cnt_nxt;
          if (hit) state_q <= StIdle;
        end
`endif
        StDrain: if (s_valid_ch && s_last_ch) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  axis_skid_buf #(
    .W (DW + 1)
  ) u_skid (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .s_data_i  ({push_last, push_data}),
    .s_valid_i (push_valid),
    .s_ready_o (buf_ready),
    .m_data_o  ({M_TLAST, M_TDATA}),
    .m_valid_o (M_TVALID),
    .m_ready_i (M_TREADY)
  );

  assign M_TKEEP     = '1;
  assign Frame_Count = fcnt_q;
  assign Frame_Err   = err_q;
  assign Active_Ch   = ch_q;

endmodule

// File: tb/tb_eth_frame_former_mc.sv
// Self-checking bench for eth_frame_former_mc: random payload bursts vs. a frame-level model.
module tb_eth_frame_former_mc;

  localparam int DB  = 8;
  localparam int NCH = 4;
  localparam int DW  = 64;
  localparam int MEM = 1024;
`ifdef ETH_FRAME_FORMER_PAD_EN
  localparam bit PadOn = 1'b1;
`else
  localparam bit PadOn = 1'b0;
`endif

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [47:0]       da, sa;
  logic [15:0]       sw;
  logic [13:0]       ps;
  logic [16*NCH-1:0] lt_bus;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH-1:0]    s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]     m_tdata;
  logic [DB-1:0]     m_tkeep;
  logic              m_tvalid, m_tlast, m_tready;
  logic [31:0]       frame_count;
  logic              frame_err;
  logic [1:0]        active_ch;

  eth_frame_former_mc #(
    .DATA_BYTES (DB),
    .NUM_CH     (NCH),
    .PS_W       (14)
  ) dut (
    .ACLK                (aclk),
    .ARESET              (areset),
    .Destination_Address (da),
    .Source_Address      (sa),
    .Link_Type           (lt_bus),
    .SyncWord            (sw),
    .Packet_Size         (ps),
    .S_TDATA             (s_tdata),
    .S_TVALID            (s_tvalid),
    .S_TLAST             (s_tlast),
    .S_TREADY            (s_tready),
    .M_TDATA             (m_tdata),
    .M_TKEEP             (m_tkeep),
    .M_TVALID            (m_tvalid),
    .M_TLAST             (m_tlast),
    .M_TREADY            (m_tready),
    .Frame_Count         (frame_count),
    .Frame_Err           (frame_err),
    .Active_Ch           (active_ch)
  );

  always #5 aclk = ~aclk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [64:0] src_mem [NCH][MEM];
  int          src_head [NCH];
  int          src_tail [NCH];
  int          model_head [NCH];
  bit          started [NCH];
  bit          gaps_en = 1'b0;
  int          rdy_mode = 0;
  int          cyc = 0;
  int          model_last = NCH - 1;
  int          exp_fc = 0;
  int          obs_err = 0;
  int          exp_err = 0;
  logic [64:0] obs_q[$];
  int          obs_cyc[$];
  logic [64:0] exp_q[$];
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;

  task automatic clear_run();
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    obs_err = 0; exp_err = 0;
    for (int c = 0; c < NCH; c++) begin
      src_head[c] = 0; src_tail[c] = 0; model_head[c] = 0; started[c] = 1'b0;
    end
  endtask

  task automatic add_burst(int c, int len);
    for (int i = 0; i < len; i++) begin
      src_mem[c][src_tail[c]] = {i == len - 1, $urandom(), $urandom()};
      src_tail[c]++;
    end
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < NCH; c++) begin
      if (src_head[c] < src_tail[c] && (!started[c] || !gaps_en || $urandom_range(3) != 0)) begin
        s_tvalid[c] = 1'b1;
        {s_tlast[c], s_tdata[DW*c +: DW]} = src_mem[c][src_head[c]];
      end else begin
        s_tvalid[c] = 1'b0;
        s_tlast[c]  = 1'b0;
        s_tdata[DW*c +: DW] = '0;
      end
    end
    case (rdy_mode)
      1:       m_tready = ($urandom_range(2) != 0);
      2:       m_tready = ((cyc % 6) >= 4);
      default: m_tready = 1'b1;
    endcase
  endtask

  // Sample everything mid-cycle; change inputs just after the rising edge.
  task automatic step();
    bit pop [NCH];
    @(negedge aclk);
    if (prev_stall) begin
      tests_run++;
      if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last) begin
        tests_failed++;
        $display("FAIL axi_stable cyc %0d: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                 cyc, m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    if (m_tvalid && m_tready) begin
      obs_q.push_back({m_tlast, m_tdata});
      obs_cyc.push_back(cyc);
    end
    if (frame_err) obs_err++;
    for (int c = 0; c < NCH; c++) pop[c] = s_tvalid[c] && s_tready[c];
    @(posedge aclk);
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      if (pop[c]) begin
        started[c] = !src_mem[c][src_head[c]][64];
        src_head[c]++;
      end
    end
    drive_inputs();
  endtask

  function automatic logic [63:0] model_hdr(int ch, int beat);
    logic [7:0]  b [16];
    logic [15:0] l;
    logic [63:0] w;
    w = '0;
    l = lt_bus[16*ch +: 16];
    for (int k = 0; k < 6; k++) begin
      b[k]     = da[47-8*k -: 8];
      b[6 + k] = sa[47-8*k -: 8];
    end
    b[12] = l[15:8]; b[13] = l[7:0]; b[14] = sw[15:8]; b[15] = sw[7:0];
    for (int j = 0; j < DB; j++) w[8*j +: 8] = b[beat*DB + j];
    return w;
  endfunction

  // One grant per queued burst, round robin over channels with bursts left.
  task automatic build_expected();
    bit more = 1'b1;
    int c, len, p;
    while (more) begin
      c = -1;
      for (int i = 1; i <= NCH; i++) begin
        int cc;
        cc = (model_last + i) % NCH;
        if (c < 0 && model_head[cc] < src_tail[cc]) c = cc;
      end
      if (c < 0) begin
        more = 1'b0;
      end else begin
        model_last = c;
        p = int'(ps);
        len = 1;
        while (src_mem[c][model_head[c] + len - 1][64] !== 1'b1) len++;
        for (int h = 0; h < 16 / DB; h++) exp_q.push_back({1'b0, model_hdr(c, h)});
        if (len >= p) begin
          for (int i = 0; i < p; i++)
            exp_q.push_back({i == p - 1, src_mem[c][model_head[c] + i][63:0]});
          if (len > p) exp_err++;
        end else begin
          exp_err++;
          for (int i = 0; i < len; i++)
            exp_q.push_back({!PadOn && i == len - 1, src_mem[c][model_head[c] + i][63:0]});
          if (PadOn) for (int i = len; i < p; i++) exp_q.push_back({i == p - 1, 64'h0});
        end
        exp_fc++;
        model_head[c] += len;
      end
    end
  endtask

  task automatic run_and_check(string name, int budget);
    int n = 0;
    build_expected();
    drive_inputs();
    while (obs_q.size() < exp_q.size() && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      tests_run++; tests_failed++;
      $display("FAIL %s timeout: got %0d beats, required %0d", name, obs_q.size(), exp_q.size());
    end
    repeat (8) step();
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s beat_count: got %0d, required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL %s beat %0d: got %h, required %h", name, i, obs_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (frame_count !== 32'(exp_fc)) begin
      tests_failed++;
      $display("FAIL %s frame_count: got %0d, required %0d", name, frame_count, exp_fc);
    end
    tests_run++;
    if (obs_err != exp_err) begin
      tests_failed++;
      $display("FAIL %s frame_err: got %0d pulses, required %0d", name, obs_err, exp_err);
    end
  endtask

  task automatic check_reset_outputs(string name);
    tests_run++;
    if (s_tready !== 4'h0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 64'h0 ||
        frame_count !== 32'h0 || frame_err !== 1'b0 || active_ch !== 2'd0 ||
        m_tkeep !== 8'hff) begin
      tests_failed++;
      $display("FAIL %s: got rdy=%h v=%b l=%b d=%h fc=%0d err=%b ch=%0d keep=%h, required zeros/keep=ff",
               name, s_tready, m_tvalid, m_tlast, m_tdata, frame_count, frame_err, active_ch,
               m_tkeep);
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    s_tvalid = '0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    model_last = NCH - 1; exp_fc = 0; prev_stall = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("reset");
    @(posedge aclk);
    #1;
    areset = 1'b0;
    model_last = NCH - 1; exp_fc = 0;
  endtask

  task automatic test_single_frame();
    clear_run(); rdy_mode = 0; gaps_en = 1'b0; ps = 14'd16;
    add_burst(0, 16);
    run_and_check("single", 200);
    tests_run++;
    if (obs_q.size() < 18 || obs_q[0] !== {1'b0, 64'h0ff0afecaf5c0bb0} ||
        obs_q[1] !== {1'b0, 64'hadde371312feca00}) begin
      tests_failed++;
      $display("FAIL single_header: got %0d beats, beat0=%h, required beat0=0ff0afecaf5c0bb0",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 65'h0);
    end
    tests_run++;
    if (obs_cyc.size() != 18 || obs_cyc[17] - obs_cyc[0] != 17) begin
      tests_failed++;
      $display("FAIL single_throughput: got %0d beats spanning %0d cycles, required 18 over 17",
               obs_cyc.size(), obs_cyc.size() > 0 ? obs_cyc[obs_cyc.size()-1] - obs_cyc[0] : -1);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int f = 0;
    do_reset();
    clear_run(); rdy_mode = 0; gaps_en = 1'b0; ps = 14'd16;
    add_burst(0, 16); add_burst(0, 16);
    for (int c = 1; c < NCH; c++) add_burst(c, 16);
    run_and_check("round_robin", 500);
    for (int i = 0; i < obs_q.size() && f < 5; i++) begin
      if (i == 0 || obs_q[i-1][64]) begin
        tests_run++;
        if (i + 1 >= obs_q.size() ||
            {obs_q[i+1][39:32], obs_q[i+1][47:40]} !== lt_bus[16*order[f] +: 16]) begin
          tests_failed++;
          $display("FAIL rr_order frame %0d: got lt %h, required %h", f,
                   i + 1 < obs_q.size() ? {obs_q[i+1][39:32], obs_q[i+1][47:40]} : 16'h0,
                   lt_bus[16*order[f] +: 16]);
        end
        f++;
      end
    end
    tests_run++;
    if (f != 5) begin
      tests_failed++;
      $display("FAIL rr_frames: got %0d frames, required 5", f);
    end
  endtask

  task automatic test_short_frame();
    clear_run(); rdy_mode = 0; gaps_en = 1'b1; ps = 14'd16;
    add_burst(1, 10);
    run_and_check("short", 300);
    tests_run++;
    if (obs_q.size() != (PadOn ? 18 : 12) || obs_err != 1) begin
      tests_failed++;
      $display("FAIL short_len: got %0d beats %0d errs, required %0d beats 1 err",
               obs_q.size(), obs_err, PadOn ? 18 : 12);
    end
  endtask

  task automatic test_long_frame();
    clear_run(); rdy_mode = 0; gaps_en = 1'b0; ps = 14'd16;
    add_burst(2, 20); add_burst(3, 16);
    run_and_check("long_drain", 300);
    tests_run++;
    if (obs_q.size() != 36 || obs_err != 1 || src_head[2] != 20) begin
      tests_failed++;
      $display("FAIL long_drain_totals: got %0d beats %0d errs %0d consumed, required 36 1 20",
               obs_q.size(), obs_err, src_head[2]);
    end
  endtask

  task automatic test_ps_zero();
    clear_run(); rdy_mode = 0; gaps_en = 1'b0; ps = 14'd0;
    add_burst(0, 4);
    drive_inputs();
    repeat (20) step();
    tests_run++;
    if (obs_q.size() != 0 || src_head[0] != 0) begin
      tests_failed++;
      $display("FAIL ps_zero: got %0d beats out %0d consumed, required 0 0",
               obs_q.size(), src_head[0]);
    end
    ps = 14'd4;
    run_and_check("ps_zero_release", 200);
  endtask

  task automatic test_backpressure();
    int fc0;
    clear_run(); rdy_mode = 2; gaps_en = 1'b1; ps = 14'd16;
    fc0 = exp_fc;
    for (int f = 0; f < 21; f++) add_burst($urandom_range(NCH - 1), 13 + $urandom_range(6));
    run_and_check("backpressure", 6000);
    tests_run++;
    if (frame_count !== 32'(fc0 + 21)) begin
      tests_failed++;
      $display("FAIL bp_frames: got %0d, required %0d", frame_count, fc0 + 21);
    end
  endtask

  task automatic test_random();
    clear_run(); rdy_mode = 1; gaps_en = 1'b1; ps = 14'd1;
    for (int f = 0; f < 8; f++) add_burst($urandom_range(NCH - 1), 1 + $urandom_range(2));
    run_and_check("random_ps1", 2000);
    clear_run(); ps = 14'($urandom_range(8, 2));
    for (int f = 0; f < 12; f++) add_burst($urandom_range(NCH - 1), 1 + $urandom_range(11));
    run_and_check("random", 4000);
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    clear_run(); rdy_mode = 0; gaps_en = 1'b0; ps = 14'd16;
    add_burst(0, 16);
    drive_inputs();
    while (obs_q.size() < 7 && n < 200) begin
      step();
      n++;
    end
    tests_run++;
    if (obs_q.size() < 7) begin
      tests_failed++;
      $display("FAIL mid_reset_start: got %0d beats, required 7", obs_q.size());
    end
    areset = 1'b1;
    clear_run();
    drive_inputs();
    @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("mid_reset");
    @(posedge aclk);
    #1;
    areset = 1'b0;
    model_last = NCH - 1; exp_fc = 0; prev_stall = 1'b0;
    rdy_mode = 1;
    add_burst(0, 16);
    run_and_check("after_reset", 400);
  endtask

  initial begin
    da = 48'hb00b5cafecaf;
    sa = 48'hf00f00cafe12;
    sw = 16'hdead;
    ps = 14'd16;
    lt_bus = {16'h0800, 16'h88b6, 16'h88b5, 16'h1337};
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
    prev_data = '0; prev_last = 1'b0;
    clear_run();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_short_frame();
    test_long_frame();
    test_ps_zero();
    test_backpressure();
    test_random();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
